mkmif_core_param: RTL and testbench
===================================

// Module: mkmif_core_param
// PURPOSE
//  Parametrised Master Key Memory interface core: SPI mode-0 master for a serial SRAM (23K640 class) with built-in SCLK gen and shifter.
//  Generalises word, address and divider widths.
//  After reset, sets the SRAM to sequential mode by itself, then serves single-word read/write requests from the host-side register wrapper.
//  Optional zeroize sweep clears the whole SRAM as key-remanence protection.
// PARAMETERS
//  DATA_WIDTH  32    word size in bits; multiple of 8, 8..64
//  ADDR_WIDTH  11    word address width; byte address must fit in 16 bits
//  DIV_WIDTH   16    width of sclk_div
//  MEM_BYTES   8192  SRAM size in bytes; sets zeroize sweep length
// PORTS
//  clk             in   1           system clock
//  reset           in   1           async, active-high reset
//  spi_sclk        out  1           SPI clock, idles low
//  spi_cs_n        out  1           SRAM chip select, active low
//  spi_do          in   1           serial data from SRAM (MISO)
//  spi_di          out  1           serial data to SRAM (MOSI)
//  read_op         in   1           start read; acted on only while ready=1
//  write_op        in   1           start write; acted on only while ready=1
//  zeroize_op      in   1           start zeroize sweep (needs MKMIF_ZEROIZE_EN)
//  ready           out  1           core idle, accepts an op
//  valid           out  1           spi_read_data holds the result of the last read
//  sclk_div        in   DIV_WIDTH   SCLK half-period in clk cycles
//  spi_addr        in   ADDR_WIDTH  word address
//  spi_write_data  in   DATA_WIDTH  write word
//  spi_read_data   out  DATA_WIDTH  read word
// BEHAVIOUR
//  Reset values: spi_sclk=0, spi_cs_n=1, spi_di=0, ready=0, valid=0, spi_read_data=0. FSM goes to INIT.
//  FSM states: INIT -> INIT_WAIT -> READY -> {READ | WRITE | ZEROIZE} -> DONE -> READY.
//  INIT: one frame of cmd 0x01 (write status) then 0x41 (sequential mode, no hold). After that, ready=1.
//  Frame:
//   - spi_cs_n falls; bits shift MSB first; spi_di changes on SCLK falling edge or at frame start.
//   - spi_do is sampled on SCLK rising edge.
//   - spi_cs_n rises one half-period after the last falling edge.
//   - spi_cs_n then stays high for at least 2 half-periods before the next frame.
//  Half-period = sclk_div clk cycles; values <2 are clamped to 2. sclk_div is latched when an op is accepted.
//  Byte address = spi_addr * (DATA_WIDTH/8), zero-extended/truncated to 16 bits. Sent as 2 bytes after the command.
//  Write frame: 0x02, addr16, spi_write_data (DATA_WIDTH bits). Read frame: 0x03, addr16, then DATA_WIDTH bits captured.
//  Accept: op sampled on the clk edge where ready=1.
//   - Priority: zeroize > read > write.
//   - On accept: ready=0 from the next cycle; valid=0; inputs are latched (changes after accept are ignored).
//  Read completion: spi_read_data loads, valid=1 and ready=1 in the same cycle (DONE). valid holds until the next accepted op.
//  Write completion: ready=1; valid stays 0.
//  Latency from accept to ready: (8+16+DATA_WIDTH)*2*div + cs setup/hold overhead (at most 4*div + 2 cycles).
//  Ops asserted while ready=0 are dropped, not queued.
//  Reset asserted mid-frame: outputs return to reset values immediately (async). The frame is abandoned and INIT reruns.
// CONFIGURATION
//  MKMIF_ZEROIZE_EN defined:
//   - zeroize_op runs one frame: 0x02, addr 0x0000, MEM_BYTES*8 zero bits.
//   - Sequential mode carries the write through the whole array.
//   - Ready returns after the frame; valid=0 and spi_read_data=0.
//  MKMIF_ZEROIZE_EN undefined: zeroize_op is ignored; no zeroize logic is built.
// TESTING
//  1. Release reset, sclk_div=2 -> one 16-bit frame 0x01,0x41 with 2-clk SCLK half-period; spi_cs_n=1 after; ready=1.
//  2. write_op, spi_addr=0x005, data=0xDEADBEEF -> frame 0x02,0x0014,0xDEADBEEF; ready back to 1; valid=0.
//  3. read_op, spi_addr=0x005, SRAM model returns 0xDEADBEEF -> frame 0x03,0x0014; spi_read_data=0xDEADBEEF; valid=1.
//  4. read_op and write_op in the same cycle, addr=0x001 -> only a read frame (0x03,0x0004); write_op pulsed again while ready=0 -> no extra frame.
//  5. reset raised at bit 20 of a write -> spi_cs_n=1 and spi_sclk=0 before the next clk edge; after release, the INIT frame 0x01,0x41 repeats.
//  6. MEM_BYTES=16, zeroize_op -> with macro: frame 0x02,0x0000 plus 128 zero bits, valid=0. Without macro: no spi_cs_n activity, ready stays 1.

Source files
------------

// File: rtl/mkmif_core_param.sv
// Parametrised Master Key Memory interface core: SPI mode-0 master for a 23K640-class serial SRAM.
// Optional zeroize sweep is built only when MKMIF_ZEROIZE_EN is defined.
module mkmif_core_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int DIV_WIDTH  = 16,
  parameter int MEM_BYTES  = 8192
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  spi_sclk,
  output logic                  spi_cs_n,
  input  logic                  spi_do,
  output logic                  spi_di,
  input  logic                  read_op,
  input  logic                  write_op,
  input  logic                  zeroize_op,
  output logic                  ready,
  output logic                  valid,
  input  logic [DIV_WIDTH-1:0]  sclk_div,
  input  logic [ADDR_WIDTH-1:0] spi_addr,
  input  logic [DATA_WIDTH-1:0] spi_write_data,
  output logic [DATA_WIDTH-1:0] spi_read_data
);

  localparam int SR_W     = 24 + DATA_WIDTH;
  localparam int ZBITS    = 24 + MEM_BYTES * 8;
  localparam int MAX_BITS = (ZBITS > SR_W) ? ZBITS : SR_W;
  localparam int CNT_W    = $clog2(MAX_BITS + 1);
  localparam int BPW      = DATA_WIDTH / 8;

  localparam logic [DIV_WIDTH:0]   H_ONE = 1;
  localparam logic [CNT_W-1:0]     B_ONE = 1;

  typedef enum logic [2:0] {
    ST_INIT, ST_INIT_WAIT, ST_READY, ST_READ, ST_WRITE, ST_DONE
`ifdef MKMIF_ZEROIZE_EN
    , ST_ZEROIZE
`endif
  } state_t;

  typedef enum logic [1:0] {PH_SHIFT, PH_HOLD, PH_GAP} phase_t;

  state_t                r_state, w_next;
  phase_t                r_phase;
  logic                  r_busy, r_sclk, r_cs_n, r_di, r_valid;
  logic [SR_W-1:0]       r_sr;
  logic [DATA_WIDTH-1:0] r_rx, r_read_data;
  logic [CNT_W-1:0]      r_bits_left;
  logic [DIV_WIDTH:0]    r_hcnt;
  logic [DIV_WIDTH-1:0]  r_div;

  logic                  w_start, w_frame_done;
  logic [SR_W-1:0]       w_start_sr;
  logic [CNT_W-1:0]      w_start_bits;
  logic [DIV_WIDTH-1:0]  w_div_now;
  logic [15:0]           w_byte_addr;

`ifndef MKMIF_ZEROIZE_EN
  logic w_unused;
  assign w_unused = zeroize_op;
`endif

  assign w_div_now    = (sclk_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : sclk_div;
  assign w_byte_addr  = 16'(32'(spi_addr) * 32'(BPW));
  assign w_frame_done = r_busy && (r_phase == PH_GAP) && (r_hcnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_INIT;
    else       r_state <= w_next;
  end

  // NOTE: every output of this block is given a default first so no path leaves a latch behind.
  always_comb begin
    w_next       = r_state;
    w_start      = 1'b0;
    w_start_sr   = '0;
    w_start_bits = '0;
    case (r_state)
      ST_INIT: begin
        w_start      = 1'b1;
        w_start_sr   = {8'h01, 8'h41, {(DATA_WIDTH + 8){1'b0}}};
        w_start_bits = CNT_W'(16);
        w_next       = ST_INIT_WAIT;
      end
      ST_INIT_WAIT: if (w_frame_done) w_next = ST_READY;
      ST_READY, ST_DONE: begin
        w_next = ST_READY;
`ifdef MKMIF_ZEROIZE_EN
        if (zeroize_op) begin
          w_start      = 1'b1;
          w_start_sr   = {8'h02, 16'h0000, {DATA_WIDTH{1'b0}}};
          w_start_bits = CNT_W'(ZBITS);
          w_next       = ST_ZEROIZE;
        end else
`endif
        if (read_op) begin
          w_start      = 1'b1;
          w_start_sr   = {8'h03, w_byte_addr, {DATA_WIDTH{1'b0}}};
          w_start_bits = CNT_W'(SR_W);
          w_next       = ST_READ;
        end else if (write_op) begin
          w_start      = 1'b1;
          w_start_sr   = {8'h02, w_byte_addr, spi_write_data};
          w_start_bits = CNT_W'(SR_W);
          w_next       = ST_WRITE;
        end
      end
      ST_READ:    if (w_frame_done) w_next = ST_DONE;
      ST_WRITE:   if (w_frame_done) w_next = ST_DONE;
`ifdef MKMIF_ZEROIZE_EN
      ST_ZEROIZE: if (w_frame_done) w_next = ST_DONE;
`endif
      default:    w_next = ST_INIT;
    endcase
  end

  // Result register: cleared on every accepted op, loaded when a read frame completes.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_read_data <= '0;
    end else begin
      if (w_start && r_state != ST_INIT) r_valid <= 1'b0;
      if (r_state == ST_READ && w_frame_done) begin
        r_valid     <= 1'b1;
        r_read_data <= r_rx;
      end
`ifdef MKMIF_ZEROIZE_EN
      if (r_state == ST_ZEROIZE && w_frame_done) r_read_data <= '0;
`endif
    end
  end

  // Frame engine: half-period counter drives SCLK; MOSI moves on falling edges, MISO sampled on rising.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy      <= 1'b0;
      r_sclk      <= 1'b0;
      r_cs_n      <= 1'b1;
      r_di        <= 1'b0;
      r_phase     <= PH_SHIFT;
      r_hcnt      <= '0;
      r_bits_left <= '0;
      r_sr        <= '0;
      r_rx        <= '0;
      r_div       <= DIV_WIDTH'(2);
    end else if (w_start) begin
      r_busy      <= 1'b1;
      r_sclk      <= 1'b0;
      r_cs_n      <= 1'b0;
      r_di        <= w_start_sr[SR_W-1];
      r_sr        <= w_start_sr;
      r_phase     <= PH_SHIFT;
      r_bits_left <= w_start_bits;
      r_div       <= w_div_now;
      r_hcnt      <= {1'b0, w_div_now} - H_ONE;
    end else if (r_busy) begin
      if (r_hcnt != '0) begin
        r_hcnt <= r_hcnt - H_ONE;
      end else begin
        r_hcnt <= {1'b0, r_div} - H_ONE;
        case (r_phase)
          PH_SHIFT: begin
            if (!r_sclk) begin
              r_sclk <= 1'b1;
              r_rx   <= {r_rx[DATA_WIDTH-2:0], spi_do};
            end else begin
              r_sclk      <= 1'b0;
              r_bits_left <= r_bits_left - B_ONE;
              if (r_bits_left == B_ONE) begin
                r_phase <= PH_HOLD;
                r_di    <= 1'b0;
              end else begin
                r_sr <= {r_sr[SR_W-2:0], 1'b0};
                r_di <= r_sr[SR_W-2];
              end
            end
          end
          PH_HOLD: begin
            r_cs_n  <= 1'b1;
            r_phase <= PH_GAP;
            r_hcnt  <= {r_div, 1'b0} - H_ONE;
          end
          PH_GAP: begin
            r_busy  <= 1'b0;
            r_phase <= PH_SHIFT;
          end
          default: r_phase <= PH_SHIFT;
        endcase
      end
    end
  end

  assign spi_sclk      = r_sclk;
  assign spi_cs_n      = r_cs_n;
  assign spi_di        = r_di;
  assign ready         = (r_state == ST_READY) || (r_state == ST_DONE);
  assign valid         = r_valid;
  assign spi_read_data = r_read_data;

endmodule

// File: tb/tb_mkmif_core_param.sv
// Self-checking bench for mkmif_core_param: behavioural 23K640 SRAM model plus a word-level scoreboard.
// Expectations for zeroize follow whether MKMIF_ZEROIZE_EN is defined for the build.
module tb_mkmif_core_param;
  localparam int DW = 32;
  localparam int AW = 11;
  localparam int VW = 16;
  localparam int MB = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          spi_sclk, spi_cs_n, spi_di, ready, valid;
  logic          spi_do = 1'b0;
  logic          read_op = 1'b0, write_op = 1'b0, zeroize_op = 1'b0;
  logic [VW-1:0] sclk_div = 16'd2;
  logic [AW-1:0] spi_addr = '0;
  logic [DW-1:0] spi_write_data = '0;
  logic [DW-1:0] spi_read_data;

  int checks = 0;
  int failures = 0;

  mkmif_core_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DIV_WIDTH(VW), .MEM_BYTES(MB)) dut (
    .clk(clk), .reset(reset), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_do(spi_do),
    .spi_di(spi_di), .read_op(read_op), .write_op(write_op), .zeroize_op(zeroize_op),
    .ready(ready), .valid(valid), .sclk_div(sclk_div), .spi_addr(spi_addr),
    .spi_write_data(spi_write_data), .spi_read_data(spi_read_data)
  );

  always #5 clk = ~clk;

  // SRAM model: records each frame MSB-first, applies writes at frame end, serves reads sequentially.
  logic [7:0]   sram [int];
  logic [DW-1:0] exp_mem [int];
  logic [255:0] cur_bits, last_bits;
  int           cur_cnt = 0, last_len = 0, frames_seen = 0;
  bit           active = 0, gap_skip = 1;
  int           exp_div = 2, gap_div = 2;
  time          t_low_start, t_last_pos, t_last_neg, t_cs_rise;

  always @(negedge spi_cs_n) begin
    if (!gap_skip) begin
      checks++;
      if ($time - t_cs_rise < 2 * gap_div * 10) begin
        failures++;
        $display("FAIL cs_gap high_time=%0t required>=%0d", $time - t_cs_rise, 2 * gap_div * 10);
      end
    end
    gap_skip = 0; active = 1; cur_cnt = 0; cur_bits = '0; t_low_start = $time; spi_do = 1'b0;
  end

  always @(posedge spi_cs_n) begin
    if (active) begin
      active = 0;
      frames_seen++;
      last_bits = cur_bits;
      last_len  = cur_cnt;
      if (cur_cnt >= 24 && cur_bits[255:248] == 8'h02)
        for (int i = 0; i < (cur_cnt - 24) / 8 && i < 29; i++)
          sram[(int'(cur_bits[247:232]) + i) % 65536] = cur_bits[231 - 8 * i -: 8];
      if (reset) gap_skip = 1;
      else begin
        checks++;
        if ($time - t_last_neg != exp_div * 10) begin
          failures++;
          $display("FAIL cs_hold time=%0t required=%0d", $time - t_last_neg, exp_div * 10);
        end
        t_cs_rise = $time;
        gap_div   = exp_div;
      end
    end
  end

  always @(posedge spi_sclk) begin
    if (active && !reset) begin
      checks++;
      if ($time - t_low_start != exp_div * 10) begin
        failures++;
        $display("FAIL sclk_low time=%0t required=%0d", $time - t_low_start, exp_div * 10);
      end
      if (cur_cnt < 256) cur_bits[255 - cur_cnt] = spi_di;
      cur_cnt++;
      t_last_pos = $time;
    end
  end

  always @(negedge spi_sclk) begin
    if (active && !reset) begin
      checks++;
      if ($time - t_last_pos != exp_div * 10) begin
        failures++;
        $display("FAIL sclk_high time=%0t required=%0d", $time - t_last_pos, exp_div * 10);
      end
      t_last_neg  = $time;
      t_low_start = $time;
      if (cur_cnt >= 24 && cur_bits[255:248] == 8'h03) begin
        int k, a;
        k = cur_cnt - 24;
        a = (int'(cur_bits[247:232]) + k / 8) % 65536;
        spi_do = sram.exists(a) ? sram[a][7 - k % 8] : 1'b0;
      end
    end
  end

  function automatic logic [23:0] exp_hdr(input logic [7:0] cmd, input int word_addr);
    return {cmd, 16'((word_addr * (DW / 8)) % 65536)};
  endfunction

  function automatic logic [DW-1:0] mem_word(input int a);
    return exp_mem.exists(a) ? exp_mem[a] : '0;
  endfunction

  task automatic wait_ready(input int budget, input string name);
    int n = 0;
    while (ready !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_timeout ready=%b after %0d cycles, required 1", name, ready, n);
    end
  endtask

  task automatic issue(input logic rd, input logic wr, input logic zr,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, input int div);
    @(negedge clk);
    sclk_div = VW'(div); exp_div = (div < 2) ? 2 : div;
    spi_addr = a; spi_write_data = d;
    read_op = rd; write_op = wr; zeroize_op = zr;
    @(negedge clk);
    read_op = 1'b0; write_op = 1'b0; zeroize_op = 1'b0;
    spi_addr = AW'($urandom); spi_write_data = $urandom;
  endtask

  task automatic check_accepted(input string name);
    checks++;
    if (ready !== 1'b0 || valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_accept ready=%b valid=%b, required 0 0", name, ready, valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({spi_sclk, spi_cs_n, spi_di, ready, valid} !== 5'b01000 || spi_read_data !== '0) begin
      failures++;
      $display("FAIL reset_values sclk,cs_n,di,ready,valid=%b data=%h, required 01000 0",
               {spi_sclk, spi_cs_n, spi_di, ready, valid}, spi_read_data);
    end
    reset = 1'b0;
    wait_ready(500, "init");
    checks++;
    if (frames_seen !== 1 || last_len !== 16 || last_bits[255:240] !== 16'h0141 || spi_cs_n !== 1'b1) begin
      failures++;
      $display("FAIL init_frame frames=%0d len=%0d bits=%h cs_n=%b, required 1 16 0141 1",
               frames_seen, last_len, last_bits[255:240], spi_cs_n);
    end
  endtask

  task automatic test_write_read();
    int f0 = frames_seen;
    issue(1'b0, 1'b1, 1'b0, 11'h005, 32'hDEADBEEF, 2);
    check_accepted("write");
    wait_ready(1000, "write");
    exp_mem[5] = 32'hDEADBEEF;
    checks++;
    if (frames_seen !== f0 + 1 || last_len !== 56 || last_bits[255:200] !== {exp_hdr(8'h02, 5), 32'hDEADBEEF} || valid !== 1'b0) begin
      failures++;
      $display("FAIL write_frame frames=%0d len=%0d bits=%h valid=%b, required %0d 56 %h 0",
               frames_seen, last_len, last_bits[255:200], valid, f0 + 1, {exp_hdr(8'h02, 5), 32'hDEADBEEF});
    end
    issue(1'b1, 1'b0, 1'b0, 11'h005, 32'h0, 2);
    check_accepted("read");
    wait_ready(1000, "read");
    checks++;
    if (last_len !== 56 || last_bits[255:232] !== 24'h030014 || spi_read_data !== 32'hDEADBEEF || valid !== 1'b1) begin
      failures++;
      $display("FAIL read_frame len=%0d hdr=%h data=%h valid=%b, required 56 030014 deadbeef 1",
               last_len, last_bits[255:232], spi_read_data, valid);
    end
  endtask

  task automatic test_priority();
    int f0 = frames_seen;
    issue(1'b1, 1'b1, 1'b0, 11'h001, $urandom, 3);
    check_accepted("prio");
    write_op = 1'b1;
    @(negedge clk);
    write_op = 1'b0;
    wait_ready(1500, "prio");
    checks++;
    if (frames_seen !== f0 + 1 || last_bits[255:232] !== 24'h030004 || spi_read_data !== mem_word(1) || valid !== 1'b1) begin
      failures++;
      $display("FAIL prio_read frames=%0d hdr=%h data=%h valid=%b, required %0d 030004 %h 1",
               frames_seen, last_bits[255:232], spi_read_data, valid, f0 + 1, mem_word(1));
    end
    repeat (200) @(negedge clk);
    checks++;
    if (frames_seen !== f0 + 1) begin
      failures++;
      $display("FAIL dropped_op frames=%0d, required %0d", frames_seen, f0 + 1);
    end
  endtask

  task automatic test_reset_mid_frame();
    int f0 = frames_seen;
    int n = 0;
    issue(1'b0, 1'b1, 1'b0, 11'h002, $urandom, 2);
    while (cur_cnt < 20 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cur_cnt < 20) begin
      failures++;
      $display("FAIL midframe_timeout bits=%0d, required 20", cur_cnt);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (spi_cs_n !== 1'b1 || spi_sclk !== 1'b0 || ready !== 1'b0 || valid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset cs_n=%b sclk=%b ready=%b valid=%b, required 1 0 0 0",
               spi_cs_n, spi_sclk, ready, valid);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_ready(500, "reinit");
    checks++;
    if (frames_seen !== f0 + 2 || last_len !== 16 || last_bits[255:240] !== 16'h0141) begin
      failures++;
      $display("FAIL reinit_frame frames=%0d len=%0d bits=%h, required %0d 16 0141",
               frames_seen, last_len, last_bits[255:240], f0 + 2);
    end
  endtask

  task automatic test_zeroize();
    int f0;
    issue(1'b0, 1'b1, 1'b0, 11'h000, 32'hA5A5_1234, 2);
    wait_ready(1000, "zpre");
    exp_mem[0] = 32'hA5A5_1234;
    f0 = frames_seen;
    issue(1'b0, 1'b0, 1'b1, 11'h003, $urandom, 2);
`ifdef MKMIF_ZEROIZE_EN
    check_accepted("zeroize");
    wait_ready(3000, "zeroize");
    for (int i = 0; i < MB / (DW / 8); i++) exp_mem[i] = '0;
    checks++;
    if (frames_seen !== f0 + 1 || last_len !== 24 + MB * 8 || last_bits[255:232] !== 24'h020000 ||
        last_bits[231:104] !== '0 || valid !== 1'b0 || spi_read_data !== '0) begin
      failures++;
      $display("FAIL zeroize_frame frames=%0d len=%0d hdr=%h valid=%b data=%h, required %0d %0d 020000 0 0",
               frames_seen, last_len, last_bits[255:232], valid, spi_read_data, f0 + 1, 24 + MB * 8);
    end
`else
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL zeroize_ignored ready=%b, required 1", ready);
    end
    repeat (300) @(negedge clk);
    checks++;
    if (frames_seen !== f0 || ready !== 1'b1) begin
      failures++;
      $display("FAIL zeroize_noframe frames=%0d ready=%b, required %0d 1", frames_seen, ready, f0);
    end
`endif
    issue(1'b1, 1'b0, 1'b0, 11'h000, 32'h0, 2);
    wait_ready(1000, "zpost");
    checks++;
    if (spi_read_data !== mem_word(0) || valid !== 1'b1) begin
      failures++;
      $display("FAIL zeroize_readback data=%h valid=%b, required %h 1", spi_read_data, valid, mem_word(0));
    end
  endtask

  task automatic test_back_to_back();
    int last_a = 5;
    for (int i = 0; i < 12; i++) begin
      logic rd;
      int a, div, f0;
      logic [DW-1:0] d;
      rd  = 1'($urandom_range(0, 1));
      a   = (rd && $urandom_range(0, 1) == 1) ? last_a : int'($urandom_range(0, 2047));
      d   = $urandom;
      div = int'($urandom_range(0, 4));
      f0  = frames_seen;
      issue(rd, !rd, 1'b0, AW'(a), d, div);
      check_accepted("b2b");
      wait_ready(1500, "b2b");
      if (rd) begin
        checks++;
        if (frames_seen !== f0 + 1 || last_bits[255:232] !== exp_hdr(8'h03, a) ||
            spi_read_data !== mem_word(a) || valid !== 1'b1) begin
          failures++;
          $display("FAIL b2b_read[%0d] hdr=%h data=%h valid=%b, required %h %h 1",
                   i, last_bits[255:232], spi_read_data, valid, exp_hdr(8'h03, a), mem_word(a));
        end
      end else begin
        exp_mem[a] = d;
        last_a = a;
        checks++;
        if (frames_seen !== f0 + 1 || last_len !== 56 || last_bits[255:200] !== {exp_hdr(8'h02, a), d} || valid !== 1'b0) begin
          failures++;
          $display("FAIL b2b_write[%0d] len=%0d bits=%h valid=%b, required 56 %h 0",
                   i, last_len, last_bits[255:200], valid, {exp_hdr(8'h02, a), d});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_priority();
    test_reset_mid_frame();
    test_zeroize();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
